// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-stage types and constants
package cpu_pkg;
  localparam int PC_W = 16;
  localparam int WAIT_W = 8;
  localparam logic [PC_W-1:0] DEFAULT_RESET_VECTOR = 16'h0000;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT_CF = 2'd1,
    HALTED  = 2'd2
  } fetch_state_t;

  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction
endpackage

// File: rtl/pc_sat_counter.sv
// rtl/pc_sat_counter.sv - saturating up-counter with synchronous clear
module pc_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - PC register and IF control (freeze on control flow, redirect, halt)
// FETCH_PERF_CNT_EN enables the redirect/stall performance counters.
module pc_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int              MAX_WAIT     = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            halt,
  input  logic            cf_decoded,
  input  logic            resolve,
  input  logic [PC_W-1:0] PC_update,
  input  logic            PC_src,
  output logic [PC_W-1:0] PC,
  output logic [PC_W-1:0] PC_plus1,
  output logic            fetch_valid,
  output logic            flush,
  output logic            halted,
  output logic            cf_timeout,
  output logic [15:0]     redirect_cnt,
  output logic [15:0]     stall_cnt
);
  fetch_state_t      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              cf_timeout_q, cf_timeout_d;
  logic              wait_clr, wait_inc, flush_raw;
  logic [WAIT_W-1:0] wait_cnt;

  pc_sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .clr (wait_clr),
    .inc (wait_inc),
    .cnt (wait_cnt)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    cf_timeout_d = cf_timeout_q;
    wait_clr     = 1'b0;
    wait_inc     = 1'b0;
    flush_raw    = 1'b0;
    case (state_q)
      RUN: begin
        if (halt) begin
          state_d = HALTED;
        end else if (!stall) begin
          pc_d = pc_inc(pc_q);
          if (cf_decoded) begin
            state_d  = WAIT_CF;
            wait_clr = 1'b1;
          end
        end
      end
      WAIT_CF: begin
        if (resolve) begin
          state_d = RUN;
          if (PC_src) begin
            pc_d      = PC_update;
            flush_raw = 1'b1;
          end
        end else begin
          wait_inc = 1'b1;
          // The counter reaches MAX_WAIT on this edge.
          if (wait_cnt >= WAIT_W'(MAX_WAIT - 1)) begin
            cf_timeout_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      pc_q         <= RESET_VECTOR;
      cf_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      cf_timeout_q <= cf_timeout_d;
    end
  end

  assign PC          = pc_q;
  assign PC_plus1    = pc_inc(pc_q);
  assign fetch_valid = !rst && (state_q == RUN) && !stall;
  assign flush       = flush_raw && !rst;
  assign halted      = (state_q == HALTED);
  assign cf_timeout  = cf_timeout_q;

`ifdef FETCH_PERF_CNT_EN
  pc_sat_counter #(.WIDTH(16)) u_redirect_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (flush),
    .cnt (redirect_cnt)
  );

  pc_sat_counter #(.WIDTH(16)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc ((state_q == RUN) && stall),
    .cnt (stall_cnt)
  );
`else
  assign redirect_cnt = 16'h0000;
  assign stall_cnt    = 16'h0000;
`endif
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - scoreboard bench for pc_fetch_ctrl against a behavioural model
module tb_pc_fetch_ctrl;
  localparam int MAX_WAIT = 8;
  localparam logic [15:0] RV = 16'h0000;

  logic        clk = 1'b0;
  logic        rst, stall, halt, cf_decoded, resolve, PC_src;
  logic [15:0] PC_update;
  logic [15:0] PC, PC_plus1, redirect_cnt, stall_cnt;
  logic        fetch_valid, flush, halted, cf_timeout;

  pc_fetch_ctrl #(.RESET_VECTOR(RV), .MAX_WAIT(MAX_WAIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .halt         (halt),
    .cf_decoded   (cf_decoded),
    .resolve      (resolve),
    .PC_update    (PC_update),
    .PC_src       (PC_src),
    .PC           (PC),
    .PC_plus1     (PC_plus1),
    .fetch_valid  (fetch_valid),
    .flush        (flush),
    .halted       (halted),
    .cf_timeout   (cf_timeout),
    .redirect_cnt (redirect_cnt),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic [15:0] pc, pc1, rc, sc;
    logic        fv, fl, hl, to;
  } exp_t;

  exp_t q[$];
  int   passes = 0;
  int   total  = 0;

  // Behavioural model: plain integers and flags, not the DUT's encoding.
  int m_pc, m_waits, m_redir, m_stalls;
  bit m_waiting, m_halted, m_to;

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.chk) begin
        check("pc", PC, e.pc);
        check("pc_plus1", PC_plus1, e.pc1);
        check("fetch_valid", {15'd0, fetch_valid}, {15'd0, e.fv});
        check("flush", {15'd0, flush}, {15'd0, e.fl});
        check("halted", {15'd0, halted}, {15'd0, e.hl});
        check("cf_timeout", {15'd0, cf_timeout}, {15'd0, e.to});
        check("redirect_cnt", redirect_cnt, e.rc);
        check("stall_cnt", stall_cnt, e.sc);
      end
    end
  end

  task automatic step(input logic r, input logic s, input logic h, input logic c,
                      input logic rv, input logic src, input logic [15:0] upd, input bit chk);
    exp_t e;
    rst = r; stall = s; halt = h; cf_decoded = c; resolve = rv; PC_src = src; PC_update = upd;
    e.chk = chk;
    e.pc  = 16'(m_pc);
    e.pc1 = 16'(m_pc + 1);
    e.hl  = m_halted;
    e.to  = m_to;
    e.fv  = !r && !m_waiting && !m_halted && !s;
    e.fl  = !r && m_waiting && rv && src;
`ifdef FETCH_PERF_CNT_EN
    e.rc = 16'(m_redir);
    e.sc = 16'(m_stalls);
`else
    e.rc = 16'h0000;
    e.sc = 16'h0000;
`endif
    q.push_back(e);
    if (r) begin
      m_pc = RV; m_waiting = 0; m_halted = 0; m_to = 0;
      m_waits = 0; m_redir = 0; m_stalls = 0;
    end else if (m_halted) begin
    end else if (m_waiting) begin
      if (rv) begin
        m_waiting = 0;
        if (src) begin
          m_pc = upd;
          m_redir = sat16(m_redir + 1);
        end
      end else begin
        m_waits++;
        if (m_waits >= MAX_WAIT) m_to = 1;
      end
    end else begin
      if (s) m_stalls = sat16(m_stalls + 1);
      if (h) m_halted = 1;
      else if (!s) begin
        m_pc = (m_pc + 1) % 65536;
        if (c) begin
          m_waiting = 1;
          m_waits = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 16'h0, 1);
  endtask

  // Reach a given PC through a taken control-flow redirect.
  task automatic jump(input logic [15:0] tgt);
    step(0, 0, 0, 1, 0, 0, 16'h0, 1);
    step(0, 0, 0, 0, 1, 1, tgt, 1);
  endtask

  initial begin
    int waited;
    rst = 1; stall = 0; halt = 0; cf_decoded = 0; resolve = 0; PC_src = 0; PC_update = 0;
    m_pc = 0; m_waiting = 0; m_halted = 0; m_to = 0; m_waits = 0; m_redir = 0; m_stalls = 0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, 0, 16'h0, 0);
    step(1, 0, 0, 0, 0, 0, 16'h0, 1);
    idle(5);
    jump(16'h0010);
    step(0, 0, 0, 1, 0, 0, 16'h0, 1);
    idle(2);
    step(0, 0, 0, 0, 1, 1, 16'h0040, 1);
    idle(2);
    jump(16'h0020);
    step(0, 0, 0, 1, 0, 0, 16'h0, 1);
    step(0, 0, 0, 0, 1, 0, 16'h1234, 1);
    idle(2);
    step(0, 0, 0, 1, 0, 0, 16'h0, 1);
    for (int i = 0; i < 9; i++) step(0, i[0], i[1], i[2], 0, 1, 16'h7777, 1);
    step(0, 0, 0, 0, 1, 1, 16'h0005, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 16'h0, 1);
    step(0, 0, 1, 0, 0, 0, 16'h0, 1);
    step(0, 0, 0, 1, 1, 1, 16'h0099, 1);
    step(0, 1, 0, 0, 1, 1, 16'h0099, 1);
    idle(2);
    step(1, 0, 0, 0, 0, 0, 16'h0, 1);
    idle(2);
    jump(16'hFFFF);
    idle(2);
    jump(16'hFFFF);
    step(0, 1, 0, 1, 0, 0, 16'h0, 1);
    idle(2);
    step(0, 0, 0, 0, 1, 1, 16'h3333, 1);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 79) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1,
           16'($urandom),
           1);
    end
    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (q.size() > 0) begin
      total++;
      $display("FAIL drain actual=%0d expected=0 pending records", q.size());
    end
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
